window_max_sequencer: RTL and testbench
=======================================

// Module: window_max_sequencer
// PURPOSE
//   Streaming front-end for the two-operand 8-bit max unit (task_max_top).
//   Accepts samples over a valid/ready handshake and drives the max unit's
//   number1/number2 inputs with the running maximum and the incoming sample.
//   Captures the max unit's result and emits one maximum per window of
//   WIN_LEN samples, or per partial window on flush, over a valid/ready output.
// PARAMETERS
//   DATA_W   8  sample width; must match the max unit operand width
//   WIN_LEN  4  samples per window; must be >= 2
//   CNT_W    $clog2(WIN_LEN+1)  derived localparam; width of count/out_len
// PORTS
//   clk         in   1        rising-edge clock
//   rst         in   1        asynchronous reset, active-high
//   in_valid    in   1        sample present on in_data
//   in_data     in   DATA_W   input sample
//   in_ready    out  1        block accepts a sample this cycle
//   flush       in   1        single-cycle pulse: close the current partial window
//   cmp_a       out  DATA_W   to max unit number1 (running max register)
//   cmp_b       out  DATA_W   to max unit number2 (in_data, combinational)
//   cmp_result  in   DATA_W   from max unit result (combinational max)
//   out_valid   out  1        window result valid
//   out_data    out  DATA_W   window maximum
//   out_len     out  CNT_W    samples contained in the window (1..WIN_LEN)
//   out_ready   in   1        downstream accepts the result
// BEHAVIOUR
//   - Reset (async, on rst high): state=ACCUM, count=0, max_reg=0, out_valid=0,
//     out_data=0, out_len=0. All state elements are cleared; a partial window
//     in progress is discarded and no output is produced for it.
//   - FSM states: ACCUM, HOLD.
//     * ACCUM: in_ready=1, out_valid=0.
//     * HOLD:  in_ready=0, out_valid=1; out_data and out_len are stable.
//   - Accept condition: in_valid & in_ready.
//   - On accept with count==0: max_reg <= in_data (cmp_result is ignored).
//   - On accept with count>0: max_reg <= cmp_result. The max unit is purely
//     combinational, so the update completes in the same cycle.
//   - Each accept increments count by 1.
//   - Ties: equal operands produce that value. No signed interpretation is applied.
//   - Window close, ACCUM -> HOLD (asserted on the next edge):
//     * an accept that makes count==WIN_LEN, or
//     * flush with count>0 (count includes any sample accepted that same cycle).
//     On close: out_data <= new max value, out_len <= new count, count <= 0.
//   - flush in ACCUM with count==0 and no accept: ignored; no output.
//   - flush while in HOLD: ignored; it is not queued.
//   - HOLD -> ACCUM: on out_valid & out_ready. in_ready is 0 during the
//     handshake cycle and returns to 1 on the next cycle.
//   - Latency: the final accepting edge sets out_valid; result is one cycle after the last sample.
//   - Throughput: at most WIN_LEN samples per WIN_LEN+1 cycles (one HOLD cycle minimum).
//   - Backpressure: HOLD persists indefinitely while out_ready=0.
//   - cmp_a = max_reg and cmp_b = in_data at all times, including when idle.
// TESTING (WIN_LEN=4, DATA_W=8, task_max_top instantiated as the comparator)
//   1. Stream 10,20,20,30 with out_ready=1 -> out_valid one cycle after the
//      4th accept; out_data=30, out_len=4; in_ready low for exactly 1 cycle.
//   2. Stream 200,7,200,5 (ties and descending values) -> out_data=200, out_len=4.
//   3. Stream 9,3, then flush on an idle cycle -> out_data=9, out_len=2.
//      Flush coincident with accepting 50 after 9,3 -> out_data=50, out_len=3.
//   4. Hold out_ready=0 for 5 cycles after close -> out_data/out_len stable,
//      in_ready=0, and in_valid samples are not consumed. Then out_ready=1
//      -> next window starts fresh (samples 1,1,1,2 -> out_data=2).
//   5. Assert rst after 2 samples, then stream 4,3,2,1 -> out_valid stays 0
//      through reset; first output is out_data=4, out_len=4.
//   6. flush with count==0, and flush during HOLD -> no extra output beat.

Source files
------------

// File: rtl/window_max_sequencer.sv
// Streaming front-end for a two-operand max unit: folds incoming samples into a
// running maximum and emits one result per full window or per flushed partial window.
module window_max_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WIN_LEN = 4,
    localparam int unsigned CNT_W  = $clog2(WIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic [DATA_W-1:0] cmp_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_len,
    input  logic              out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [DATA_W-1:0] max_reg;
    logic [DATA_W-1:0] max_next;
    logic              accept;
    logic              close;

    // Window bookkeeping: the first sample of a window bypasses the comparator
    // so a stale maximum from the previous window never leaks forward.
    always_comb begin
        accept    = in_valid & in_ready;
        count_inc = count + CNT_W'(accept);
        max_next  = max_reg;
        if (accept) begin
            max_next = (count == '0) ? in_data : cmp_result;
        end
        close = (state == ACCUM) &&
                ((accept && (count_inc == CNT_W'(WIN_LEN))) ||
                 (flush && (count_inc != '0)));
    end

    assign cmp_a = max_reg;
    assign cmp_b = in_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (close) state_next = HOLD;
            HOLD:  if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: in_ready = 1'b1;
            HOLD:  out_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: running max, sample count and the held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            max_reg  <= '0;
            out_data <= '0;
            out_len  <= '0;
        end else begin
            if (accept) begin
                max_reg <= max_next;
            end
            if (close) begin
                count    <= '0;
                out_data <= max_next;
                out_len  <= count_inc;
            end else if (accept) begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_window_max_sequencer.sv
// Self-checking bench for window_max_sequencer: directed scenarios plus a
// randomized run against a queue-based window model.
module tb_window_max_sequencer;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned WIN_LEN = 4;
    localparam int unsigned CNT_W   = $clog2(WIN_LEN + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic [DATA_W-1:0] cmp_result;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_len;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    // Model state
    bit                m_hold;
    logic [DATA_W-1:0] m_win[$];
    logic [DATA_W-1:0] m_last;
    logic [DATA_W-1:0] m_out_data;
    int                m_out_len;
    int                m_beats;
    int                dut_beats;

    window_max_sequencer #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_result(cmp_result),
        .out_valid(out_valid), .out_data(out_data), .out_len(out_len),
        .out_ready(out_ready)
    );

    // Behavioural stand-in for the combinational max unit
    assign cmp_result = (cmp_a >= cmp_b) ? cmp_a : cmp_b;

    always #5 clk = ~clk;

    function automatic void model_clear();
        m_hold = 1'b0;
        m_win.delete();
        m_last = '0;
        m_out_data = '0;
        m_out_len = 0;
    endfunction

    // Drive one cycle of inputs, advance the model over the rising edge,
    // and return at posedge+1 with outputs settled.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit f, input bit r);
        logic [DATA_W-1:0] mx;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        #1;
        if (out_valid && out_ready) dut_beats++;
        @(posedge clk);
        if (!m_hold) begin
            if (v) begin
                m_win.push_back(d);
                mx = m_win[0];
                foreach (m_win[i]) if (m_win[i] > mx) mx = m_win[i];
                m_last = mx;
            end
            if ((v && m_win.size() == WIN_LEN) || (f && m_win.size() > 0)) begin
                m_out_data = m_last;
                m_out_len  = m_win.size();
                m_win.delete();
                m_hold = 1'b1;
            end
        end else if (r) begin
            m_hold = 1'b0;
            m_beats++;
        end
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic feed(input logic [DATA_W-1:0] a, b, c, d);
        cycle(1, a, 0, 1);
        cycle(1, b, 0, 1);
        cycle(1, c, 0, 1);
        cycle(1, d, 0, 1);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        checks++; if (out_len !== 3'd0) begin errors++; $display("FAIL reset_out_len got %0d exp 0", out_len); end
        checks++; if (cmp_a !== 8'd0) begin errors++; $display("FAIL reset_cmp_a got %0d exp 0", cmp_a); end
    endtask

    task automatic test_basic_window();
        cycle(1, 10, 0, 1);
        cycle(1, 20, 0, 1);
        cycle(1, 20, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %0b exp 0", out_valid); end
        checks++; if (cmp_a !== 8'd20) begin errors++; $display("FAIL t1_cmp_a got %0d exp 20", cmp_a); end
        in_data = 8'd77; #1;
        checks++; if (cmp_b !== 8'd77) begin errors++; $display("FAIL t1_cmp_b got %0d exp 77", cmp_b); end
        cycle(1, 30, 0, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0b exp 1", out_valid); end
        checks++; if (out_data !== 8'd30) begin errors++; $display("FAIL t1_data got %0d exp 30", out_data); end
        checks++; if (out_len !== 3'd4) begin errors++; $display("FAIL t1_len got %0d exp 4", out_len); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t1_in_ready_hold got %0b exp 0", in_ready); end
        cycle(0, 0, 0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t1_in_ready_back got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop got %0b exp 0", out_valid); end
    endtask

    task automatic test_ties();
        feed(200, 7, 200, 5);
        checks++; if (out_data !== 8'd200) begin errors++; $display("FAIL t2_data got %0d exp 200", out_data); end
        checks++; if (out_len !== 3'd4) begin errors++; $display("FAIL t2_len got %0d exp 4", out_len); end
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_flush();
        cycle(1, 9, 0, 1);
        cycle(1, 3, 0, 1);
        cycle(0, 0, 1, 0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd9) begin errors++; $display("FAIL t3_idle_flush got v=%0b d=%0d exp v=1 d=9", out_valid, out_data); end
        checks++; if (out_len !== 3'd2) begin errors++; $display("FAIL t3_idle_len got %0d exp 2", out_len); end
        cycle(0, 0, 0, 1);
        cycle(1, 9, 0, 1);
        cycle(1, 3, 0, 1);
        cycle(1, 50, 1, 0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd50) begin errors++; $display("FAIL t3_coinc_flush got v=%0b d=%0d exp v=1 d=50", out_valid, out_data); end
        checks++; if (out_len !== 3'd3) begin errors++; $display("FAIL t3_coinc_len got %0d exp 3", out_len); end
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        feed(5, 6, 7, 8);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'($urandom), 0, 0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd8 || out_len !== 3'd4 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL t4_stall%0d got v=%0b d=%0d l=%0d r=%0b exp v=1 d=8 l=4 r=0",
                         i, out_valid, out_data, out_len, in_ready);
            end
        end
        cycle(0, 0, 0, 1);
        feed(1, 1, 1, 2);
        checks++; if (out_data !== 8'd2 || out_len !== 3'd4) begin errors++; $display("FAIL t4_fresh got d=%0d l=%0d exp d=2 l=4", out_data, out_len); end
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_midreset();
        cycle(1, 11, 0, 1);
        cycle(1, 12, 0, 1);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        model_clear();
        #1;
        checks++; if (out_valid !== 1'b0 || cmp_a !== 8'd0) begin errors++; $display("FAIL t5_in_reset got v=%0b a=%0d exp v=0 a=0", out_valid, cmp_a); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_reset_valid got %0b exp 0", out_valid); end
        rst = 1'b0;
        cycle(1, 4, 0, 1);
        cycle(1, 3, 0, 1);
        cycle(1, 2, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_stale_window got %0b exp 0", out_valid); end
        cycle(1, 1, 0, 1);
        checks++; if (out_data !== 8'd4 || out_len !== 3'd4) begin errors++; $display("FAIL t5_first got d=%0d l=%0d exp d=4 l=4", out_data, out_len); end
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_ignored_flush();
        int base;
        base = dut_beats;
        cycle(0, 0, 1, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_empty_flush got %0b exp 0", out_valid); end
        feed(40, 41, 42, 43);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL t6_hold_flush got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready); end
        cycle(0, 0, 0, 1);
        checks++; if (dut_beats - base !== 1) begin errors++; $display("FAIL t6_beats got %0d exp 1", dut_beats - base); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) != 0));
            checks++;
            if (in_ready !== !m_hold || out_valid !== m_hold) begin
                errors++;
                $display("FAIL rnd_hs%0d got r=%0b v=%0b exp r=%0b v=%0b", i, in_ready, out_valid, !m_hold, m_hold);
            end
            if (m_hold) begin
                checks++;
                if (out_data !== m_out_data || out_len !== CNT_W'(m_out_len)) begin
                    errors++;
                    $display("FAIL rnd_out%0d got d=%0d l=%0d exp d=%0d l=%0d", i, out_data, out_len, m_out_data, m_out_len);
                end
            end
            checks++;
            if (cmp_a !== m_last) begin
                errors++;
                $display("FAIL rnd_cmp_a%0d got %0d exp %0d", i, cmp_a, m_last);
            end
        end
        checks++;
        if (dut_beats !== m_beats) begin errors++; $display("FAIL rnd_beats got %0d exp %0d", dut_beats, m_beats); end
    endtask

    initial begin
        m_beats = 0;
        dut_beats = 0;
        test_reset();
        test_basic_window();
        test_ties();
        test_flush();
        test_backpressure();
        test_midreset();
        test_ignored_flush();
        m_beats = 0;
        dut_beats = 0;
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
